// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   - Legal oversampling ratios and the fallback used for any other value
//   - Parity type encodings as driven on PAR_TYP
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Maps a raw prescale request onto a supported ratio; anything that is not
  // 16 or 32 runs at 8 so the counters always see a known bit period.
  function automatic int prescale_cycles(input int raw);
    case (raw)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing and sampling for the UART receiver.
//   CLK, RST      : clock, synchronous active-high reset
//   rx_in         : serial line (already synchronous)
//   frame_start   : FSM is idle and sees a low line this cycle (edge 0)
//   frame_active  : FSM is outside IDLE
//   data_phase    : FSM is receiving data bits
//   prescale      : latched cycles-per-bit for the current frame
//   bit_cnt       : index of the data bit being received
//   sampled_bit   : majority vote of the three mid-bit samples
//   bit_end       : current cycle is the last edge (P-1) of a bit
//   sample_done   : sampled_bit has just been updated for the current bit
module uart_rx_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          rx_in,
  input  logic                          frame_start,
  input  logic                          frame_active,
  input  logic                          data_phase,
  input  logic [PRESCALE_W-1:0]         prescale,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt,
  output logic                          sampled_bit,
  output logic                          bit_end,
  output logic                          sample_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] half;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  vote_q, vote_d;
  logic                  done_q, done_d;

  assign half    = prescale >> 1;
  assign bit_end = frame_active && (edge_cnt_q == prescale - PRESCALE_W'(1));

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    vote_d     = vote_q;
    done_d     = 1'b0;

    // The detecting cycle is edge 0 of the start bit, so the counter resumes at 1.
    if (frame_start) begin
      edge_cnt_d = PRESCALE_W'(1);
    end else if (!frame_active || bit_end) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end

    if (!frame_active) begin
      bit_cnt_d = '0;
    end else if (bit_end && data_phase) begin
      bit_cnt_d = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
    end

    // Samples at P/2-1 and P/2 are stored; the live line at P/2+1 completes the vote.
    if (frame_active) begin
      if (edge_cnt_q == half - PRESCALE_W'(1)) s0_d = rx_in;
      if (edge_cnt_q == half)                  s1_d = rx_in;
      if (edge_cnt_q == half + PRESCALE_W'(1)) begin
        vote_d = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge only; RST has no asynchronous path.
    if (RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      vote_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      vote_q     <= vote_d;
      done_q     <= done_d;
    end
  end

  assign bit_cnt     = bit_cnt_q;
  assign sampled_bit = vote_q;
  assign sample_done = done_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start, LSB-first data, optional parity and stop bits.
//   CLK, RST   : clock, synchronous active-high reset
//   RX_IN      : serial line, idle high, synchronous to CLK
//   PAR_EN     : a parity bit follows the data bits
//   PAR_TYP    : 0 even parity, 1 odd parity
//   Prescale   : CLK cycles per bit (8/16/32, anything else runs as 8)
//   P_DATA     : last good word, held until the next good frame
//   Data_Valid : one-cycle pulse when P_DATA updates
//   Par_Err    : one-cycle pulse at the end of a frame with bad parity
//   Stp_Err    : one-cycle pulse at the end of a frame with a low stop bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_fail_q, par_fail_d;
  logic                  stp_fail_q, stp_fail_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic [BIT_W-1:0] bit_cnt;
  logic             sampled_bit, bit_end, sample_done;
  logic             frame_start, expected_par;

  assign frame_start  = (state_q == ST_IDLE) && !RX_IN;
  assign expected_par = (par_typ_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

  uart_rx_sampler #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_in        (RX_IN),
    .frame_start  (frame_start),
    .frame_active (state_q != ST_IDLE),
    .data_phase   (state_q == ST_DATA),
    .prescale     (prescale_q),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .bit_end      (bit_end),
    .sample_done  (sample_done)
  );

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    shift_d      = shift_q;
    par_fail_d   = par_fail_q;
    stp_fail_d   = stp_fail_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d    = ST_START;
          prescale_d = PRESCALE_W'(prescale_cycles(int'(Prescale)));
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          stp_fail_d = 1'b0;
        end
      end
      ST_START: begin
        // A start bit that votes high was noise; drop back silently.
        if (bit_end) state_d = sampled_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_done) shift_d[bit_cnt] = sampled_bit;
        if (bit_end && (bit_cnt == BIT_W'(DATA_WIDTH - 1))) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (sample_done && (sampled_bit != expected_par)) par_fail_d = 1'b1;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample_done && !sampled_bit) stp_fail_d = 1'b1;
        if (bit_end) begin
          state_d   = ST_IDLE;
          par_err_d = par_fail_q;
          stp_err_d = stp_fail_q;
          if (!par_fail_q && !stp_fail_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shift_q      <= '0;
      par_fail_q   <= 1'b0;
      stp_fail_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      shift_q      <= shift_d;
      par_fail_q   <= par_fail_d;
      stp_fail_q   <= stp_fail_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign Par_Err    = par_err_q;
  assign Stp_Err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames are driven bit by bit on falling
// edges, output pulses are logged with their cycle number, and each scenario
// task compares the log against hand-computed cycle counts and data.
module tb_uart_rx;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         dv_cyc[$];
  logic [7:0] dv_data[$];
  int         pe_cyc[$];
  int         se_cyc[$];

  uart_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Data_Valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_data.push_back(P_DATA);
    end
    if (Par_Err === 1'b1) pe_cyc.push_back(cyc);
    if (Stp_Err === 1'b1) se_cyc.push_back(cyc);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    wait_neg(n);
  endtask

  task automatic clear_log();
    dv_cyc.delete();
    dv_data.delete();
    pe_cyc.delete();
    se_cyc.delete();
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Drives one whole frame starting at the current falling edge; t0 is the
  // cycle in which the line first goes low.
  task automatic send_frame(input logic [5:0] pre, input int p, input logic [7:0] data,
                            input logic par_en, input logic par_typ, input logic par_bit,
                            input logic stop_bit, output int t0);
    Prescale = pre;
    PAR_EN   = par_en;
    PAR_TYP  = par_typ;
    RX_IN    = 1'b0;
    t0       = cyc;
    wait_neg(p);
    for (int i = 0; i < 8; i++) begin
      RX_IN = data[i];
      wait_neg(p);
    end
    if (par_en) begin
      RX_IN = par_bit;
      wait_neg(p);
    end
    RX_IN = stop_bit;
    wait_neg(p);
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    wait_neg(3);
    checks++; if (P_DATA !== 8'h00) begin failures++; $display("FAIL reset_p_data: got %0h want 00", P_DATA); end
    checks++; if (Data_Valid !== 1'b0) begin failures++; $display("FAIL reset_dv: got %b want 0", Data_Valid); end
    checks++; if (Par_Err !== 1'b0) begin failures++; $display("FAIL reset_par_err: got %b want 0", Par_Err); end
    checks++; if (Stp_Err !== 1'b0) begin failures++; $display("FAIL reset_stp_err: got %b want 0", Stp_Err); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    RST = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_good_frame();
    int t0;
    clear_log();
    send_frame(6'd8, 8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    idle(5);
    checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL good_dv_count: got %0d want 1", dv_cyc.size()); end
    checks++; if (first_of(dv_cyc) !== t0 + 80) begin failures++; $display("FAIL good_dv_time: got %0d want %0d", first_of(dv_cyc), t0 + 80); end
    checks++; if (P_DATA !== 8'hA5) begin failures++; $display("FAIL good_p_data: got %0h want a5", P_DATA); end
    checks++; if (pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL good_no_err: got %0d pulses want 0", pe_cyc.size() + se_cyc.size()); end
    // Unsupported prescale 12 must run with 8-cycle bits.
    clear_log();
    send_frame(6'd12, 8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    idle(5);
    checks++; if (first_of(dv_cyc) !== t0 + 80) begin failures++; $display("FAIL illegal_pre_time: got %0d want %0d", first_of(dv_cyc), t0 + 80); end
    checks++; if (P_DATA !== 8'h3C) begin failures++; $display("FAIL illegal_pre_data: got %0h want 3c", P_DATA); end
  endtask

  task automatic test_parity_error();
    int t0;
    clear_log();
    // 0x3C has four ones, so even parity expects 0; drive 1.
    send_frame(6'd16, 16, 8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, t0);
    idle(5);
    checks++; if (pe_cyc.size() !== 1) begin failures++; $display("FAIL par_err_count: got %0d want 1", pe_cyc.size()); end
    checks++; if (first_of(pe_cyc) !== t0 + 176) begin failures++; $display("FAIL par_err_time: got %0d want %0d", first_of(pe_cyc), t0 + 176); end
    checks++; if (dv_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL par_err_others: got %0d pulses want 0", dv_cyc.size() + se_cyc.size()); end
    checks++; if (P_DATA !== 8'h3C) begin failures++; $display("FAIL par_err_hold: got %0h want 3c", P_DATA); end
  endtask

  task automatic test_stop_error();
    int t0;
    clear_log();
    send_frame(6'd8, 8, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(5);
    checks++; if (se_cyc.size() !== 1) begin failures++; $display("FAIL stp_err_count: got %0d want 1", se_cyc.size()); end
    checks++; if (first_of(se_cyc) !== t0 + 80) begin failures++; $display("FAIL stp_err_time: got %0d want %0d", first_of(se_cyc), t0 + 80); end
    checks++; if (dv_cyc.size() + pe_cyc.size() !== 0) begin failures++; $display("FAIL stp_err_others: got %0d pulses want 0", dv_cyc.size() + pe_cyc.size()); end
    checks++; if (P_DATA !== 8'h3C) begin failures++; $display("FAIL stp_err_hold: got %0h want 3c", P_DATA); end
  endtask

  task automatic test_glitch();
    int t0;
    clear_log();
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    t0       = cyc;
    wait_neg(3);
    RX_IN = 1'b1;
    wait_neg(12);
    checks++; if (dut.state_q !== ST_START) begin failures++; $display("FAIL glitch_state_p15: got %0d want %0d (cycle %0d)", dut.state_q, ST_START, cyc - t0); end
    wait_neg(1);
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL glitch_state_p16: got %0d want %0d (cycle %0d)", dut.state_q, ST_IDLE, cyc - t0); end
    idle(200);
    checks++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL glitch_no_pulse: got %0d pulses want 0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    clear_log();
    // Odd parity: 0x00 and 0xFF both have an even count of ones, so parity bit = 1.
    send_frame(6'd32, 32, 8'h00, 1'b1, PAR_ODD, 1'b1, 1'b1, t0a);
    send_frame(6'd32, 32, 8'hFF, 1'b1, PAR_ODD, 1'b1, 1'b1, t0b);
    idle(5);
    checks++; if (dv_cyc.size() !== 2) begin failures++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cyc.size()); end
    if (dv_cyc.size() == 2) begin
      checks++; if (dv_cyc[0] !== t0a + 352) begin failures++; $display("FAIL b2b_first_time: got %0d want %0d", dv_cyc[0], t0a + 352); end
      checks++; if (dv_cyc[1] !== t0a + 704) begin failures++; $display("FAIL b2b_second_time: got %0d want %0d", dv_cyc[1], t0a + 704); end
      checks++; if (dv_data[0] !== 8'h00) begin failures++; $display("FAIL b2b_first_data: got %0h want 00", dv_data[0]); end
      checks++; if (dv_data[1] !== 8'hFF) begin failures++; $display("FAIL b2b_second_data: got %0h want ff", dv_data[1]); end
    end
    checks++; if (pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL b2b_no_err: got %0d pulses want 0", pe_cyc.size() + se_cyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int         t0;
    logic [7:0] d;
    d = 8'h5A;
    clear_log();
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    wait_neg(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      wait_neg(8);
    end
    RX_IN = d[4];
    wait_neg(4);
    RST   = 1'b1;
    RX_IN = 1'b1;
    wait_neg(2);
    checks++; if (P_DATA !== 8'h00) begin failures++; $display("FAIL midrst_p_data: got %0h want 00", P_DATA); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL midrst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    RST = 1'b0;
    idle(100);
    checks++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
    clear_log();
    send_frame(6'd8, 8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    idle(5);
    checks++; if (first_of(dv_cyc) !== t0 + 80) begin failures++; $display("FAIL midrst_next_time: got %0d want %0d", first_of(dv_cyc), t0 + 80); end
    checks++; if (P_DATA !== 8'h81) begin failures++; $display("FAIL midrst_next_data: got %0h want 81", P_DATA); end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    @(negedge CLK);
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
